// File: rtl/serial_bit_feeder_if.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder_if
// Groups the word-side handshake and the serial-side outputs of the
// serial_bit_feeder into one bundle.
//   master : producer/consumer view (drives data_in/data_valid, observes rest)
//   slave  : feeder view (samples data_in/data_valid, drives the outputs)
// Signals:
//   data_in    [WIDTH]  word to serialise
//   data_valid          producer offers data_in
//   data_ready          holding register empty
//   x_out               serial bit towards the downstream FSM x_in
//   x_valid             x_out carries a word (or parity) bit
//   word_done           final bit of a word is on x_out
//   busy                shifting or holding a word
// -----------------------------------------------------------------------------
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             x_out;
  logic             x_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  x_out,
    input  x_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output x_out,
    output x_valid,
    output word_done,
    output busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
// Parallel-to-serial feeder: accepts WIDTH-bit words over a valid/ready
// handshake into a one-entry holding register and presents them LSB first,
// one bit per clock, on x_out. The holding register lets the next word follow
// the current one without a gap.
//
// Ports:
//   i_clk    rising-edge clock shared with the downstream FSM
//   i_rst_n  asynchronous active-low reset, clears all state
//   bus      serial_bit_feeder_if.slave (data_in, data_valid, data_ready,
//            x_out, x_valid, word_done, busy)
//
// Configuration macro:
//   FEEDER_PARITY_EN  when defined, an even-parity bit (XOR of all WIDTH data
//                     bits) follows every word and word_done marks that bit.
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  serial_bit_feeder_if.slave  bus
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LP_LAST = CW'(WIDTH - 1);

`ifdef FEEDER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
  } state_t;
`endif

`ifdef FEEDER_PARITY_EN
  // Even parity over a full word.
  function automatic logic f_parity(input logic [WIDTH-1:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      p = p ^ d[i];
    end
    return p;
  endfunction
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_hold;
  logic [WIDTH-1:0]  w_hold_nxt;
  logic              r_hold_full;
  logic              w_hold_full_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
`ifdef FEEDER_PARITY_EN
  logic              r_parity;
  logic              w_parity_nxt;
`endif

  logic              w_accept;
  logic              w_last;
  logic              w_load;

  // Next-state logic: word transfer from hold into the shifter, shifting,
  // and acceptance of a new word into the empty holding register.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
`ifdef FEEDER_PARITY_EN
    w_parity_nxt    = r_parity;
`endif
    w_load          = 1'b0;
    w_accept        = bus.data_valid & ~r_hold_full;
    w_last          = (r_state == ST_SHIFT) && (r_cnt == LP_LAST);

    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_SHIFT: begin
        w_shift_nxt = r_shift >> 1;
        w_cnt_nxt   = r_cnt + CW'(1);
        if (w_last) begin
`ifdef FEEDER_PARITY_EN
          w_state_nxt = ST_PARITY;
          w_cnt_nxt   = '0;
`else
          // Last data bit: chain the held word in directly, or fall idle.
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
`endif
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef FEEDER_PARITY_EN
      ST_PARITY: begin
        // Parity bit is the final cycle of a word; same chaining rule.
        if (r_hold_full) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A transfer needs hold_full=1 and an accept needs hold_full=0, so the
    // two are mutually exclusive on any edge; the transfer frees the hold
    // and data_ready rises for the following cycle.
    if (w_load) begin
      w_shift_nxt     = r_hold;
      w_cnt_nxt       = '0;
      w_state_nxt     = ST_SHIFT;
      w_hold_full_nxt = 1'b0;
`ifdef FEEDER_PARITY_EN
      w_parity_nxt    = f_parity(r_hold);
`endif
    end else if (w_accept) begin
      w_hold_nxt      = bus.data_in;
      w_hold_full_nxt = 1'b1;
    end else begin
      w_hold_full_nxt = r_hold_full;
    end
  end

  // State, hold, shifter and counter registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
`ifdef FEEDER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef FEEDER_PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  // Serial-side outputs decoded from registered state only.
  always_comb begin
    bus.x_out     = 1'b0;
    bus.x_valid   = 1'b0;
    bus.word_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.x_out     = 1'b0;
        bus.x_valid   = 1'b0;
        bus.word_done = 1'b0;
      end
      ST_SHIFT: begin
        bus.x_out     = r_shift[0];
        bus.x_valid   = 1'b1;
`ifdef FEEDER_PARITY_EN
        bus.word_done = 1'b0;
`else
        bus.word_done = (r_cnt == LP_LAST);
`endif
      end
`ifdef FEEDER_PARITY_EN
      ST_PARITY: begin
        bus.x_out     = r_parity;
        bus.x_valid   = 1'b1;
        bus.word_done = 1'b1;
      end
`endif
      default: begin
        bus.x_out     = 1'b0;
        bus.x_valid   = 1'b0;
        bus.word_done = 1'b0;
      end
    endcase
  end

  // Handshake status: ready tracks the empty hold, busy covers any pending work.
  always_comb begin
    bus.data_ready = ~r_hold_full;
    bus.busy       = (r_state != ST_IDLE) | r_hold_full;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
// Self-checking bench for serial_bit_feeder (WIDTH=8). A queue-based reference
// model holds the pending serial bits and the one-entry hold buffer; every
// cycle the DUT outputs are compared against it, alongside directed checks
// of the scenarios called out for this block.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_bit_feeder_if #(.WIDTH(W)) bus_if ();

  serial_bit_feeder #(.WIDTH(W)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic b;
    logic d;
  } ent_t;

  ent_t         m_q[$];
  logic         m_hold_full;
  logic [W-1:0] m_hold;

  function automatic void model_reset();
    m_q.delete();
    m_hold_full = 1'b0;
    m_hold      = '0;
  endfunction

  // Queue up every bit a word will present, in order.
  function automatic void model_push_word(input logic [W-1:0] w);
    ent_t e;
    logic p;
    p = 1'b0;
    for (int i = 0; i < W; i++) begin
      e.b = w[i];
      p   = p ^ w[i];
`ifdef FEEDER_PARITY_EN
      e.d = 1'b0;
`else
      e.d = (i == W - 1);
`endif
      m_q.push_back(e);
    end
`ifdef FEEDER_PARITY_EN
    e.b = p;
    e.d = 1'b1;
    m_q.push_back(e);
`endif
  endfunction

  // One rising edge: current bit retires; an empty stream pulls the held
  // word in; otherwise an offered word lands in an empty hold.
  function automatic void model_edge(input logic v, input logic [W-1:0] d);
    logic acc;
    acc = v && !m_hold_full;
    if (m_q.size() != 0) void'(m_q.pop_front());
    if (m_q.size() == 0 && m_hold_full) begin
      model_push_word(m_hold);
      m_hold_full = 1'b0;
    end else if (acc) begin
      m_hold      = d;
      m_hold_full = 1'b1;
    end
  endfunction

  // Expected {x_valid, x_out, word_done, busy, data_ready}.
  function automatic logic [4:0] model_exp();
    logic xv, xo, wd;
    xv = (m_q.size() != 0);
    xo = xv ? m_q[0].b : 1'b0;
    wd = xv ? m_q[0].d : 1'b0;
    return {xv, xo, wd, xv | m_hold_full, ~m_hold_full};
  endfunction

  function automatic logic [4:0] dut_out();
    return {bus_if.x_valid, bus_if.x_out, bus_if.word_done, bus_if.busy, bus_if.data_ready};
  endfunction

  // Drive inputs for one cycle, advance DUT and model, land on the falling edge.
  task automatic step(input logic v, input logic [W-1:0] d);
    bus_if.data_valid = v;
    bus_if.data_in    = d;
    @(posedge clk);
    if (rst_n) model_edge(v, d);
    else       model_reset();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF);
      checks++;
      if (dut_out() !== 5'b00001) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, dut_out(), 5'b00001);
      end
    end
    bus_if.data_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 8'h00);
    checks++;
    if (dut_out() !== 5'b00001) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", dut_out(), 5'b00001);
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] w;
    w = 8'hA5;
    step(1'b1, w);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 8'h00);
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL single_model cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
`ifndef FEEDER_PARITY_EN
      if (k <= 8) begin
        checks++;
        if (bus_if.x_out !== w[k-1] || bus_if.word_done !== (k == 8)) begin
          errors++;
          $display("FAIL single_bit cyc=%0d got=%b/%b exp=%b/%b",
                   k, bus_if.x_out, bus_if.word_done, w[k-1], (k == 8));
        end
      end else begin
        checks++;
        if (bus_if.x_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
          errors++;
          $display("FAIL single_idle got xv=%b busy=%b exp 0/0", bus_if.x_valid, bus_if.busy);
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w2;
    int           nvalid;
    w2     = 8'h3C;
    nvalid = 0;
    step(1'b1, 8'hA5);               // cycle 0
    step(1'b0, 8'h00);               // cycle 1
    step(1'b0, 8'h00);               // cycle 2
    for (int k = 3; k <= 18; k++) begin
      step((k == 3), w2);            // valid during cycle 2, accepted at edge 3
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
      if (bus_if.x_valid === 1'b1) nvalid++;
`ifndef FEEDER_PARITY_EN
      if (k <= 8) begin
        checks++;
        if (bus_if.data_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_low cyc=%0d got=%b exp=0", k, bus_if.data_ready);
        end
      end else if (k <= 16) begin
        checks++;
        if (bus_if.data_ready !== 1'b1 || bus_if.x_out !== w2[k-9]) begin
          errors++;
          $display("FAIL b2b_word2 cyc=%0d got rdy=%b x=%b exp rdy=1 x=%b",
                   k, bus_if.data_ready, bus_if.x_out, w2[k-9]);
        end
      end
`endif
    end
`ifndef FEEDER_PARITY_EN
    // cycles 1 and 2 were valid too; 16 in total across cycles 1..16
    checks++;
    if (nvalid + 2 !== 16) begin
      errors++;
      $display("FAIL b2b_valid_count got=%0d exp=16", nvalid + 2);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] obs;
    int             nb;
    obs = '0;
    nb  = 0;
    for (int k = 0; k < 24; k++) begin
      if      (k == 0) step(1'b1, 8'hA5);
      else if (k == 2) step(1'b1, 8'h5A);
      else if (k >= 3 && k < 8)  step(1'b1, 8'h11);
      else if (k >= 8 && k < 14) step(1'b1, 8'h22);
      else if (k == 1) step(1'b0, 8'h00);
      else step(1'b0, 8'h00);
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL bp_model cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
      if (bus_if.x_valid === 1'b1 && nb < 2*W) begin
        obs[nb] = bus_if.x_out;
        nb++;
      end
    end
`ifndef FEEDER_PARITY_EN
    checks++;
    if (obs !== 16'h5AA5 || nb !== 16) begin
      errors++;
      $display("FAIL bp_stream got=%h/%0d exp=5aa5/16", obs, nb);
    end
`endif
  endtask

  task automatic test_reset_mid_word();
    step(1'b1, 8'hA5);               // accept
    step(1'b0, 8'h00);               // bit 0
    step(1'b1, 8'h3C);               // bit 1, hold fills
    step(1'b0, 8'h00);               // bit 2
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_out() !== 5'b00001) begin
      errors++;
      $display("FAIL mid_reset_async got=%b exp=%b", dut_out(), 5'b00001);
    end
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    step(1'b1, 8'h01);
    step(1'b0, 8'h00);
    checks++;
    if (bus_if.x_valid !== 1'b1 || bus_if.x_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_restart got xv=%b x=%b exp 1/1", bus_if.x_valid, bus_if.x_out);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 8'h00);
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL mid_reset_model cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
    end
  endtask

`ifdef FEEDER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w;
    logic [8:0]   exp_bits;
    for (int t = 0; t < 2; t++) begin
      w        = (t == 0) ? 8'h07 : 8'h03;
      exp_bits = (t == 0) ? 9'b1_0000_0111 : 9'b0_0000_0011;
      step(1'b1, w);
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, 8'h00);
        if (k <= 9) begin
          checks++;
          if (bus_if.x_valid !== 1'b1 || bus_if.x_out !== exp_bits[k-1] ||
              bus_if.word_done !== (k == 9)) begin
            errors++;
            $display("FAIL parity_bit w=%h cyc=%0d got=%b/%b exp=%b/%b",
                     w, k, bus_if.x_out, bus_if.word_done, exp_bits[k-1], (k == 9));
          end
        end else begin
          checks++;
          if (dut_out() !== 5'b00001) begin
            errors++;
            $display("FAIL parity_idle w=%h got=%b exp=%b", w, dut_out(), 5'b00001);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic         v;
    logic [W-1:0] d;
    for (int k = 0; k < 800; k++) begin
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      step(v, d);
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
    end
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 8'h00);
      checks++;
      if (dut_out() !== model_exp()) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%b exp=%b", k, dut_out(), model_exp());
      end
    end
  endtask

  // Test sequence.
  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus_if.data_valid = 1'b0;
    bus_if.data_in    = '0;
    model_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
`ifdef FEEDER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial feeder that accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on a serial line. It sits directly upstream of the serial Mealy state machine: x_out drives that machine's x_in, and both share the same clock and reset. A one-entry holding register keeps the serial stream gap-free across word boundaries.

## Interface
- WIDTH, 8, bits per word; legal range 2..32
- clock  input  1  rising-edge clock shared with the downstream FSM
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- data_in  input  WIDTH  word to serialise; sampled only on an accepting edge
- data_valid  input  1  producer offers data_in
- data_ready  output  1  holding register empty; equals !hold_full
- x_out  output  1  serial bit to the downstream x_in; 0 whenever x_valid=0
- x_valid  output  1  x_out carries a word bit (or parity bit)
- word_done  output  1  high during the cycle presenting the final bit of a word
- busy  output  1  high when state!=IDLE or hold_full=1

## Operation
- Storage: hold register + hold_full flag, shift register, bit counter (clog2(WIDTH+1) bits), state register.
- Accept: on a rising edge with data_valid=1 and data_ready=1, data_in is written to hold and hold_full is set. With data_ready=0, data_valid and data_in are ignored; there is no overflow.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- IDLE: x_valid=0. If hold_full=1, the next edge moves hold into the shifter, clears hold_full, zeroes the counter and enters SHIFT.
- SHIFT: x_out = shifter[0], LSB first. Each edge shifts the register right and increments the counter.
  - The last bit is the cycle where counter==WIDTH-1.
  - On the last-bit edge without parity: if hold_full=1, reload from hold and stay in SHIFT with no gap; otherwise go to IDLE.
- PARITY: a single cycle. On its edge, reload from hold or go to IDLE, using the same rule as the last-bit edge.
- Transfer vs. accept on the same edge: the transfer wins. data_ready was 0 during that cycle, so no new accept is possible. hold_full clears and data_ready rises for the next cycle.
- Reset asserted mid-word: the word and the hold contents are discarded, and the state goes to IDLE asynchronously. After release, the next accepted word starts at bit 0.
- Reset values: x_out=0, x_valid=0, word_done=0, busy=0, data_ready=1, state=IDLE, counter=0, hold_full=0.

## Timing
- Word accepted at edge N: bit 0 is on x_out from edge N+1. Bit k is valid during cycle N+1+k.
- Latency from the accept edge to the first bit is 1 cycle from IDLE. When the hold is filled while shifting, the word follows the previous one with no gap.
- A word occupies exactly WIDTH cycles, or WIDTH+1 with parity.
- word_done, x_valid and x_out are combinational from registered state only, with no input-to-output paths. data_ready is combinational from hold_full only.
- The downstream FSM samples x_out on each rising edge while x_valid=1.
- Sustained throughput is one word per WIDTH (or WIDTH+1) cycles. data_ready is low from the accept edge until the transfer edge.

## Configuration
- FEEDER_PARITY_EN defined: after the WIDTH data bits, PARITY presents one extra bit, the XOR of all WIDTH bits of the word (even parity). word_done moves to the parity cycle.
- Not defined: the PARITY state and parity logic are absent, and words are exactly WIDTH bits.

## Test plan
- Reset: hold reset=0 with data_valid=1 and data_in=8'hFF → x_out=0, x_valid=0, busy=0, word_done=0, data_ready=1, and no accept.
- Single word: 8'hA5 accepted at edge 0 → x_out=1,0,1,0,0,1,0,1 in cycles 1–8, word_done only in cycle 8, x_valid=0 and busy=0 in cycle 9.
- Back-to-back: accept 8'hA5, then 8'h3C in cycle 2 → 16 consecutive x_valid=1 cycles. Second word's LSB-first bits 0,0,1,1,1,1,0,0 in cycles 9–16. data_ready=0 in cycles 3–8, 1 from cycle 9.
- Parity (FEEDER_PARITY_EN): 8'h07 → bits 1,1,1,0,0,0,0,0, then parity bit 1 in cycle 9 with word_done=1. With 8'h03 the parity bit is 0.
- Reset mid-word: assert reset after 3 bits of 8'hA5 with hold holding 8'h3C → x_valid=0 and data_ready=1 immediately. After release, accepting 8'h01 yields x_out=1 in the first cycle.
- Backpressure: hold full, data_valid=1, data_in changed 8'h11→8'h22 → ignored; only the previously held word is serialised.
